// File: rtl/sram_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_serial_ctrl
// Brief    : Serial word assembly and request-based write/read sequencing for
//            the SRAM macro. Optional readback shifter: SRAM_SERIAL_CTRL_READBACK_EN
// Revision : 1.0
// ============================================================================
module sram_serial_ctrl #(
    parameter int ROWS   = 16,
    parameter int COLS   = 8,
    parameter int LANES  = 1,
    parameter int RD_LAT = 1,
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [LANES-1:0] serial_in,
    input  logic             shift,
    input  logic             w_req,
    input  logic             r_req,
    input  logic [AW-1:0]    addr,
    output logic             word_ready,
    output logic             busy,
    output logic             err,
    output logic [AW-1:0]    mem_addr,
    output logic [COLS-1:0]  mem_wdata,
    output logic             mem_w_en,
    output logic             mem_r_en,
    input  logic [COLS-1:0]  mem_rdata,
    output logic             data_valid,
    output logic [COLS-1:0]  data_out
`ifdef SRAM_SERIAL_CTRL_READBACK_EN
    ,
    output logic [LANES-1:0] serial_out,
    output logic             serial_out_valid
`endif
);

    localparam int c_NSH = COLS / LANES;
    localparam int c_CW  = $clog2(c_NSH + 1);
    localparam logic [c_CW-1:0] c_NSH_V = c_CW'(c_NSH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    state_t           r_state;
    logic [COLS-1:0]  r_shreg;
    logic [c_CW-1:0]  r_cnt;
    logic [2:0]       r_lat;
    logic             r_busy;
    logic             r_err;
    logic [AW-1:0]    r_mem_addr;
    logic [COLS-1:0]  r_mem_wdata;
    logic             r_mem_w_en;
    logic             r_mem_r_en;
    logic             r_data_valid;
    logic [COLS-1:0]  r_data_out;

    logic [COLS-1:0]  w_shreg_next;
    logic             w_word_ready;
    logic             w_idle;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_err;

    generate
        if (LANES == COLS) begin : g_full_lane
            assign w_shreg_next = serial_in;
        end else begin : g_part_lane
            assign w_shreg_next = {r_shreg[COLS-LANES-1:0], serial_in};
        end
    endgenerate

    assign w_word_ready = (r_cnt == c_NSH_V);
    assign w_idle       = (r_state == S_IDLE);
    assign w_wr_acc     = w_idle & w_req & w_word_ready;
    assign w_rd_acc     = w_idle & r_req & ~w_req;
    // A simultaneous w_req/r_req is always flagged, even when the write goes ahead.
    assign w_err        = (~w_idle & (w_req | r_req))
                        | (w_idle & w_req & (~w_word_ready | r_req));

    always_ff @(posedge clk) begin
        if (srst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            if (shift) begin
                r_shreg <= w_shreg_next;
            end
            if (w_wr_acc) begin
                r_cnt <= shift ? c_CW'(1) : '0;
            end else if (shift) begin
                r_cnt <= w_word_ready ? c_CW'(1) : r_cnt + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= S_IDLE;
            r_lat        <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_w_en   <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_err        <= w_err;
            r_mem_w_en   <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        r_state     <= S_WRITE;
                        r_mem_addr  <= addr;
                        r_mem_wdata <= r_shreg;
                        r_mem_w_en  <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_rd_acc) begin
                        r_state    <= S_READ;
                        r_mem_addr <= addr;
                        r_mem_r_en <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_READ: begin
                    r_state <= S_RWAIT;
                    r_lat   <= 3'(RD_LAT - 1);
                end
                S_RWAIT: begin
                    // Last wait cycle is the one in which the macro data is valid.
                    if (r_lat == 3'd0) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_data_out   <= mem_rdata;
                        r_data_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready = w_word_ready;
    assign busy       = r_busy;
    assign err        = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_w_en   = r_mem_w_en;
    assign mem_r_en   = r_mem_r_en;
    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;

`ifdef SRAM_SERIAL_CTRL_READBACK_EN
    logic [COLS-1:0] r_oshreg;
    logic [c_CW-1:0] r_ocnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_oshreg <= '0;
            r_ocnt   <= '0;
        end else if (r_data_valid) begin
            r_oshreg <= r_data_out;
            r_ocnt   <= c_NSH_V;
        end else if (r_ocnt != '0) begin
            r_oshreg <= r_oshreg << LANES;
            r_ocnt   <= r_ocnt - c_CW'(1);
        end
    end

    assign serial_out       = r_oshreg[COLS-1 -: LANES];
    assign serial_out_valid = (r_ocnt != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_serial_ctrl
// Brief    : Directed scoreboard bench for sram_serial_ctrl (ROWS=16, COLS=8,
//            LANES=2, RD_LAT=1) with a behavioural macro model.
// Revision : 1.0
// ============================================================================
module tb_sram_serial_ctrl;

    logic       clk = 1'b0;
    logic       srst;
    logic [1:0] serial_in;
    logic       shift, w_req, r_req;
    logic [3:0] addr;
    logic       word_ready, busy, err, mem_w_en, mem_r_en, data_valid;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, data_out;
`ifdef SRAM_SERIAL_CTRL_READBACK_EN
    logic [1:0] serial_out;
    logic       serial_out_valid;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [11:0] q_wr[$];
    logic [3:0]  q_rd_addr[$];
    logic [7:0]  q_rd_data[$];
    logic [7:0]  exp_mem[16];
    logic [7:0]  mem_model[16];

    always #5 clk = ~clk;

    sram_serial_ctrl #(.ROWS(16), .COLS(8), .LANES(2), .RD_LAT(1)) dut (
        .clk(clk), .srst(srst), .serial_in(serial_in), .shift(shift),
        .w_req(w_req), .r_req(r_req), .addr(addr), .word_ready(word_ready),
        .busy(busy), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_rdata(mem_rdata),
        .data_valid(data_valid), .data_out(data_out)
`ifdef SRAM_SERIAL_CTRL_READBACK_EN
        , .serial_out(serial_out), .serial_out_valid(serial_out_valid)
`endif
    );

    // Macro model: one-cycle read latency after the read strobe.
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_w_en) mem_model[mem_addr] <= mem_wdata;
        if (mem_r_en) mem_rdata <= mem_model[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (srst === 1'b0) begin
            if (mem_w_en) begin
                chk("wr_q_nonempty", 32'(q_wr.size() > 0), 32'd1);
                if (q_wr.size() > 0) chk("sb_write", 32'({mem_addr, mem_wdata}), 32'(q_wr.pop_front()));
            end
            if (mem_r_en) begin
                chk("rd_addr_q_nonempty", 32'(q_rd_addr.size() > 0), 32'd1);
                if (q_rd_addr.size() > 0) chk("sb_rd_addr", 32'(mem_addr), 32'(q_rd_addr.pop_front()));
            end
            if (data_valid) begin
                chk("rd_q_nonempty", 32'(q_rd_data.size() > 0), 32'd1);
                if (q_rd_data.size() > 0) chk("sb_rd_data", 32'(data_out), 32'(q_rd_data.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            shift     = 1'b1;
            serial_in = w[7-2*i -: 2];
            tick();
        end
        shift = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        shift_word(d, 4);
        chk("wr_word_ready", 32'(word_ready), 32'd1);
        w_req = 1'b1;
        addr  = a;
        q_wr.push_back({a, d});
        exp_mem[a] = d;
        tick();
        w_req = 1'b0;
        chk("wr_w_en", 32'(mem_w_en), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'(a));
        chk("wr_data", 32'(mem_wdata), 32'(d));
        chk("wr_ready_clr", 32'(word_ready), 32'd0);
        tick();
        chk("wr_w_en_off", 32'(mem_w_en), 32'd0);
        chk("wr_busy_off", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a);
        r_req = 1'b1;
        addr  = a;
        q_rd_addr.push_back(a);
        q_rd_data.push_back(exp_mem[a]);
        tick();
        r_req = 1'b0;
        chk("rd_r_en", 32'(mem_r_en), 32'd1);
        chk("rd_busy1", 32'(busy), 32'd1);
        tick();
        chk("rd_r_en_off", 32'(mem_r_en), 32'd0);
        chk("rd_busy2", 32'(busy), 32'd1);
        chk("rd_dv_early", 32'(data_valid), 32'd0);
        tick();
        chk("rd_dv", 32'(data_valid), 32'd1);
        chk("rd_data", 32'(data_out), 32'(exp_mem[a]));
        chk("rd_busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        srst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            shift     = 1'($urandom);
            w_req     = 1'($urandom);
            r_req     = 1'($urandom);
            serial_in = 2'($urandom);
            addr      = 4'($urandom);
            tick();
        end
        chk("rst_word_ready", 32'(word_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_r_en", 32'(mem_r_en), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        srst = 1'b0; shift = 1'b0; w_req = 1'b0; r_req = 1'b0; serial_in = 2'b00; addr = 4'd0;
        tick();

        // Assembly 10,11,00,01 -> 8'hB1 written to address 5.
        do_write(4'd5, 8'hB1);

        // Read of address 5 with a second read attempted while busy.
        r_req = 1'b1; addr = 4'd5;
        q_rd_addr.push_back(4'd5);
        q_rd_data.push_back(8'hB1);
        tick();
        chk("rd5_r_en", 32'(mem_r_en), 32'd1);
        chk("rd5_busy", 32'(busy), 32'd1);
        chk("rd5_err0", 32'(err), 32'd0);
        addr = 4'd9;
        tick();
        r_req = 1'b0;
        chk("busy_rej_err", 32'(err), 32'd1);
        chk("busy_rej_r_en", 32'(mem_r_en), 32'd0);
        chk("rd5_busy2", 32'(busy), 32'd1);
        tick();
        chk("rd5_dv", 32'(data_valid), 32'd1);
        chk("rd5_data", 32'(data_out), 32'hB1);
        chk("rd5_busy_off", 32'(busy), 32'd0);
`ifdef SRAM_SERIAL_CTRL_READBACK_EN
        begin
            logic [7:0] rb;
            rb = 8'hB1;
            tick();
            for (int i = 0; i < 4; i++) begin
                chk("rb_valid", 32'(serial_out_valid), 32'd1);
                chk("rb_bits", 32'(serial_out), 32'(rb[7-2*i -: 2]));
                tick();
            end
            chk("rb_valid_off", 32'(serial_out_valid), 32'd0);
        end
`endif

        // Write request with only three shifts done.
        shift_word(8'h6C, 3);
        w_req = 1'b1; addr = 4'd2;
        tick();
        w_req = 1'b0;
        chk("short_err", 32'(err), 32'd1);
        chk("short_w_en", 32'(mem_w_en), 32'd0);
        chk("short_busy", 32'(busy), 32'd0);
        shift = 1'b1; serial_in = 2'b00;
        tick();
        shift = 1'b0;
        chk("fourth_ready", 32'(word_ready), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);

        // Simultaneous requests: the write goes ahead, the read is dropped.
        w_req = 1'b1; r_req = 1'b1; addr = 4'd3;
        q_wr.push_back({4'd3, 8'h6C});
        exp_mem[3] = 8'h6C;
        tick();
        w_req = 1'b0; r_req = 1'b0;
        chk("both_err", 32'(err), 32'd1);
        chk("both_w_en", 32'(mem_w_en), 32'd1);
        chk("both_r_en", 32'(mem_r_en), 32'd0);
        tick();
        chk("both_busy_off", 32'(busy), 32'd0);
        chk("both_r_en_late", 32'(mem_r_en), 32'd0);

        // Boundary addresses.
        for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a * 37 + 11));
        do_read(4'd15);
        do_read(4'd0);
        do_read(4'd3);

        // Reset in the middle of a read discards the partial word and the read.
        shift_word(8'hF0, 2);
        r_req = 1'b1; addr = 4'd7;
        tick();
        r_req = 1'b0;
        chk("mid_r_en", 32'(mem_r_en), 32'd1);
        srst = 1'b1;
        q_rd_addr.delete();
        q_rd_data.delete();
        tick();
        srst = 1'b0;
        chk("mid_rst_r_en", 32'(mem_r_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(word_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_dv", 32'(data_valid), 32'd0);
        end
        shift_word(8'h5A, 2);
        chk("partial_discarded", 32'(word_ready), 32'd0);
        shift_word(8'h5A, 2);
        chk("fresh_word_ready", 32'(word_ready), 32'd1);

        tick();
        tick();
        chk("wr_q_drained", 32'(q_wr.size()), 32'd0);
        chk("rd_q_drained", 32'(q_rd_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_serial_ctrl.md
# sram_serial_ctrl

Parametrised front-end controller for the mixed-signal SRAM macro. It assembles write words from a multi-lane serial input and sequences single-cycle write and read commands to the macro. It returns read data with a registered valid pulse. It replaces the single-lane shift/load/w_en/r_en handshake with a request-based interface, configurable lane count and read latency, and error flagging.

## Interface

Parameters:
- ROWS, 16, number of SRAM words; AW = $clog2(ROWS)
- COLS, 8, word width in bits; must be a multiple of LANES
- LANES, 1, serial bits accepted per shift cycle
- RD_LAT, 1, macro read latency in cycles, valid range 1..7

Ports:
- clk  in  1  single clock; all logic on rising edge
- srst  in  1  reset, synchronous, active-high
- serial_in  in  LANES  serial data; serial_in[LANES-1] is the more significant bit
- shift  in  1  shift serial_in into the assembly register this cycle
- w_req  in  1  write the assembled word to addr
- r_req  in  1  read addr
- addr  in  AW  request address, sampled when a request is accepted
- word_ready  out  1  assembly register holds a complete word
- busy  out  1  command in flight; requests are not accepted
- err  out  1  one-cycle pulse on a rejected request
- mem_addr  out  AW  macro address
- mem_wdata  out  COLS  macro write data
- mem_w_en  out  1  macro write strobe
- mem_r_en  out  1  macro read strobe
- mem_rdata  in  COLS  macro read data
- data_valid  out  1  one-cycle pulse when data_out is updated
- data_out  out  COLS  last read word, held until the next read completes

## Operation

- Assembly: on shift, shreg <= {shreg[COLS-LANES-1:0], serial_in}. Word is MSB-first. A counter counts shifts; word_ready=1 after COLS/LANES shifts.
- A shift while word_ready=1 starts a new word: the counter goes to 1 and word_ready drops.
- Shifting is legal in any FSM state.
- FSM states:
  - IDLE to WRITE on an accepted w_req.
  - IDLE to READ on an accepted r_req.
  - WRITE to IDLE after one cycle.
  - READ to RWAIT.
  - RWAIT to IDLE after RD_LAT-1 further cycles. If RD_LAT=1, RWAIT lasts one cycle.
- Write acceptance requires IDLE, w_req=1 and word_ready=1. On acceptance:
  - mem_wdata <= shreg and mem_addr <= addr.
  - word_ready clears, and the counter goes to 0.
  - If shift is also asserted that cycle, the new bits start the next word (counter=1).
- Read acceptance requires IDLE and r_req=1 with w_req=0. On acceptance, mem_addr <= addr.
- Rejections (err=1 for one cycle; no state change):
  - w_req while word_ready=0.
  - Any request while busy.
  - w_req and r_req together. The write proceeds if it is legal; the r_req is dropped.
- Reset mid-command: the strobe drops the next cycle, the FSM goes to IDLE, and the partial word is discarded. An in-flight read never produces data_valid.

## Timing

- Reset value of every output is 0, including data_out, mem_wdata and mem_addr.
- Write accepted in cycle N:
  - mem_w_en=1 and busy=1 in N+1 only.
  - Next request can be accepted in N+2.
- Read accepted in cycle N:
  - mem_r_en=1 in N+1 only.
  - mem_rdata is sampled in cycle N+1+RD_LAT.
  - data_out updates and data_valid=1 in N+2+RD_LAT.
  - busy=1 from N+1 through N+1+RD_LAT.
  - Next request can be accepted in N+2+RD_LAT.
- mem_addr and mem_wdata are stable for the whole time busy=1.
- word_ready rises in the cycle after the final shift.

## Configuration

- SRAM_SERIAL_CTRL_READBACK_EN
- Defined:
  - Adds serial_out (out, LANES) and serial_out_valid (out, 1).
  - In the data_valid cycle, the read word is loaded into an output shifter.
  - The word is emitted MSB-first, LANES bits per cycle, over the next COLS/LANES cycles, with serial_out_valid=1.
  - A new data_valid restarts the shifter and aborts any word in progress.
  - Reset clears the shifter.
- Undefined: the ports and logic are absent. All other behaviour is identical.

## Test plan

All scenarios use ROWS=16, COLS=8, LANES=2, RD_LAT=1.
- Reset: hold srst for 2 cycles with random inputs -> all outputs 0; busy=0, word_ready=0.
- Assembly and write: shift 2'b10, 2'b11, 2'b00, 2'b01 -> word_ready=1 next cycle. Then w_req with addr=5 -> mem_w_en for one cycle, mem_addr=5, mem_wdata=8'hB1, word_ready=0.
- Read: r_req with addr=5 at cycle N -> mem_r_en at N+1. Macro drives 8'hB1 at N+2 -> data_out=8'hB1 and data_valid=1 at N+3; busy=1 at N+1..N+2.
- Errors:
  - w_req with only 3 shifts done -> err pulse, no mem_w_en.
  - r_req during busy -> err pulse, no second mem_r_en.
  - w_req and r_req together with word_ready=1 -> write proceeds, err=1.
- Boundary addresses: full write of addr 0..15, then read addr 15 and addr 0 -> correct data from the macro model, mem_addr never out of range.
- Readback (SRAM_SERIAL_CTRL_READBACK_EN defined): read returns 8'hB1 -> serial_out 2'b10, 2'b11, 2'b00, 2'b01 over 4 cycles with serial_out_valid=1.
